time_set_ctrl: RTL and testbench



---
 rtl/time_set_pkg.sv | 23 ++
 rtl/btn_step.sv | 77 +++++++
 rtl/time_set_ctrl.sv | 120 ++++++++++++
 tb/tb_time_set_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and constants for the time/alarm setting controller.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HRS  = 2'd1,
    SET_MINS = 2'd2
  } state_e;

  localparam int HOURS_MAX = 23;
  localparam int MINS_MAX  = 59;
  localparam int FIELD_W   = 8;
  localparam int CH_W      = 3;

  // One up/down step of a 0..max field with wrap in both directions.
  function automatic logic [FIELD_W-1:0] wrap_step(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] max,
                                                   input logic               up);
    if (up) return (v >= max) ? '0 : v + 1'b1;
    else    return (v == '0) ? max : v - 1'b1;
  endfunction

endpackage

// File: rtl/btn_step.sv
// Button edge detector producing one-cycle step pulses.
// With AUTO_REPEAT_EN defined, a held button repeats: first repeat
// HOLD_CYCLES after the press edge, then every REPEAT_CYCLES.
module btn_step #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic step_o
);

  logic btn_q;
  logic press;

  // Elaboration-time sanity check of the repeat timing.
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_step: HOLD_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  // Previous sample of the button for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign press = btn_i & ~btn_q;

`ifdef AUTO_REPEAT_EN
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt_q, rpt_d;   // 0: waiting out the hold delay, 1: repeating
  logic          rstep;

  // cnt_q holds the number of cycles since the last step while held.
  always_comb begin
    cnt_d = cnt_q;
    rpt_d = rpt_q;
    rstep = 1'b0;
    if (!btn_i) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (!btn_q) begin
      cnt_d = CW'(1);
      rpt_d = 1'b0;
    end else if (!rpt_q && cnt_q == CW'(HOLD_CYCLES)) begin
      rstep = 1'b1;
      cnt_d = CW'(1);
      rpt_d = 1'b1;
    end else if (rpt_q && cnt_q == CW'(REPEAT_CYCLES)) begin
      rstep = 1'b1;
      cnt_d = CW'(1);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Repeat counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rpt_q <= rpt_d;
    end
  end

  assign step_o = press | rstep;
`else
  assign step_o = press;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Time/alarm setting controller: selects a channel, edits hours then
// minutes with wrapping up/down steps, times out when idle and strobes
// time_load when a channel-0 edit ends.
// Optional macro AUTO_REPEAT_EN enables press-and-hold auto-repeat.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int NUM_ALARMS     = 1,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             btn_set,
  input  logic                             btn_up,
  input  logic                             btn_down,
  input  logic [CH_W-1:0]                  ch_sel,
  output logic [FIELD_W*(NUM_ALARMS+1)-1:0] ch_hours,
  output logic [FIELD_W*(NUM_ALARMS+1)-1:0] ch_mins,
  output logic                             editing,
  output logic                             edit_field,
  output logic [CH_W-1:0]                  edit_ch,
  output logic                             time_load
);

  localparam int NUM_CH = NUM_ALARMS + 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  state_e                          state_q, state_d;
  logic   [CH_W-1:0]               ch_q, ch_d;
  logic   [TW-1:0]                 tmo_q, tmo_d;
  logic                            load_q, load_d;
  logic   [NUM_CH-1:0][FIELD_W-1:0] hrs_q, hrs_d, mins_q, mins_d;
  logic                            set_q, set_edge;
  logic                            up_step, dn_step, do_step, activity;

  btn_step #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .step_o(up_step)
  );
  btn_step #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dn (
    .clk(clk), .reset(reset), .btn_i(btn_down), .step_o(dn_step)
  );

  assign set_edge = btn_set & ~set_q;
  // Opposing steps in one cycle cancel; any button pulse still counts as activity.
  assign do_step  = up_step ^ dn_step;
  assign activity = up_step | dn_step | set_edge;

  // Next-state, field edits, inactivity timer and load strobe.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tmo_d   = tmo_q;
    load_d  = 1'b0;
    hrs_d   = hrs_q;
    mins_d  = mins_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (set_edge && 32'(ch_sel) < NUM_CH) begin
          state_d = SET_HRS;
          ch_d    = ch_sel;
        end
      end
      SET_HRS, SET_MINS: begin
        // Step lands on the current field before any state advance.
        if (do_step) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
              if (state_q == SET_HRS)
                hrs_d[c] = wrap_step(hrs_q[c], FIELD_W'(HOURS_MAX), up_step);
              else
                mins_d[c] = wrap_step(mins_q[c], FIELD_W'(MINS_MAX), up_step);
            end
          end
        end
        if (set_edge) state_d = (state_q == SET_HRS) ? SET_MINS : IDLE;
        if (activity)                          tmo_d = '0;
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
        else                                   tmo_d = tmo_q + 1'b1;
        if (state_d == IDLE) begin
          load_d = (ch_q == '0);
          ch_d   = '0;
          tmo_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tmo_q   <= '0;
      load_q  <= 1'b0;
      hrs_q   <= '0;
      mins_q  <= '0;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tmo_q   <= tmo_d;
      load_q  <= load_d;
      hrs_q   <= hrs_d;
      mins_q  <= mins_d;
      set_q   <= btn_set;
    end
  end

  assign ch_hours   = hrs_q;
  assign ch_mins    = mins_q;
  assign editing    = (state_q != IDLE);
  assign edit_field = (state_q == SET_MINS);
  assign edit_ch    = ch_q;
  assign time_load  = load_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed vector table, hand
// sequences for timeout / hold / reset corners, and random stimulus
// against a behavioural model of the setting rules.
module tb_time_set_ctrl;

  localparam int NUM_ALARMS = 2;
  localparam int NUM_CH     = NUM_ALARMS + 1;
  localparam int HOLD       = 5;
  localparam int REPEAT     = 3;
  localparam int TIMEOUT    = 20;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  btn_set, btn_up, btn_down;
  logic [2:0]            ch_sel;
  logic [8*NUM_CH-1:0]   ch_hours, ch_mins;
  logic                  editing, edit_field, time_load;
  logic [2:0]            edit_ch;

  int checks = 0;
  int errors = 0;
  bit load_seen;

  time_set_ctrl #(
    .NUM_ALARMS(NUM_ALARMS), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REPEAT), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .btn_set(btn_set), .btn_up(btn_up),
    .btn_down(btn_down), .ch_sel(ch_sel), .ch_hours(ch_hours),
    .ch_mins(ch_mins), .editing(editing), .edit_field(edit_field),
    .edit_ch(edit_ch), .time_load(time_load)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_hrs[NUM_CH];
  int m_mins[NUM_CH];
  int m_mode;      // 0 idle, 1 hours, 2 minutes
  int m_ch, m_idle;
  bit m_load;
  int age_up, age_dn;
  bit m_pset;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  // n = number of consecutive earlier samples the button was already high.
  function automatic bit is_step(input bit lvl, input int n);
    if (!lvl) return 1'b0;
    if (n == 0) return 1'b1;
    return AR && n >= HOLD && ((n - HOLD) % REPEAT) == 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin m_hrs[c] = 0; m_mins[c] = 0; end
      m_mode = 0; m_ch = 0; m_idle = 0; m_load = 0;
      age_up = 0; age_dn = 0; m_pset = 0;
    end else begin
      bit u, d, s;
      int nxt;
      u = is_step(btn_up, age_up);
      d = is_step(btn_down, age_dn);
      s = btn_set && !m_pset;
      age_up = btn_up ? age_up + 1 : 0;
      age_dn = btn_down ? age_dn + 1 : 0;
      m_pset = btn_set;
      m_load = 0;
      if (m_mode == 0) begin
        if (s && int'(ch_sel) < NUM_CH) begin m_mode = 1; m_ch = int'(ch_sel); m_idle = 0; end
      end else begin
        if (u != d) begin
          if (m_mode == 1) m_hrs[m_ch]  = (m_hrs[m_ch]  + (u ? 1 : -1) + 24) % 24;
          else             m_mins[m_ch] = (m_mins[m_ch] + (u ? 1 : -1) + 60) % 60;
        end
        if (u || d || s) m_idle = 0; else m_idle++;
        nxt = m_mode;
        if (s) nxt = (m_mode == 1) ? 2 : 0;
        if (m_idle >= TIMEOUT) nxt = 0;
        if (nxt == 0) begin m_load = (m_ch == 0); m_ch = 0; m_idle = 0; end
        m_mode = nxt;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [8*NUM_CH-1:0] eh, em;
    for (int c = 0; c < NUM_CH; c++) begin
      eh[8*c +: 8] = 8'(m_hrs[c]);
      em[8*c +: 8] = 8'(m_mins[c]);
    end
    chk({tag, ".hours"},   64'(ch_hours), 64'(eh));
    chk({tag, ".mins"},    64'(ch_mins),  64'(em));
    chk({tag, ".editing"}, 64'(editing),  64'(m_mode != 0));
    chk({tag, ".field"},   64'(edit_field), 64'(m_mode == 2));
    chk({tag, ".ch"},      64'(edit_ch),  64'(m_ch));
    chk({tag, ".load"},    64'(time_load), 64'(m_load));
  endtask

  // Drive inputs for one cycle (from a negedge), then check after the edge.
  task automatic cyc(input bit s, input bit u, input bit d, input logic [2:0] sel, input string tag);
    btn_set = s; btn_up = u; btn_down = d; ch_sel = sel;
    @(negedge clk);
    load_seen |= time_load;
    chk_model(tag);
  endtask

  task automatic press(input bit s, input bit u, input bit d, input logic [2:0] sel, input string tag);
    cyc(s, u, d, sel, tag);
    cyc(0, 0, 0, sel, tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       s, u, d;
    logic [2:0] sel;
    logic       ed, fld;
    logic [2:0] ech;
    logic       ld;
    logic [7:0] h0, m0;
  } vec_t;

  function automatic vec_t mk(bit s, bit u, bit d, int sel, bit ed, bit fld,
                              int ech, bit ld, int h0, int m0);
    vec_t v;
    v.s = s; v.u = u; v.d = d; v.sel = 3'(sel);
    v.ed = ed; v.fld = fld; v.ech = 3'(ech); v.ld = ld;
    v.h0 = 8'(h0); v.m0 = 8'(m0);
    return v;
  endfunction

  vec_t tv[24];
  int   hold_exp[14];

  initial begin
    //           s u d sel  ed fld ch ld h0 m0
    tv[0]  = mk(1,0,0,0,   1, 0, 0, 0, 0, 0);
    tv[1]  = mk(0,0,0,0,   1, 0, 0, 0, 0, 0);
    tv[2]  = mk(0,1,0,0,   1, 0, 0, 0, 1, 0);
    tv[3]  = mk(0,0,0,0,   1, 0, 0, 0, 1, 0);
    tv[4]  = mk(0,1,0,0,   1, 0, 0, 0, 2, 0);
    tv[5]  = mk(0,0,0,0,   1, 0, 0, 0, 2, 0);
    tv[6]  = mk(0,1,0,0,   1, 0, 0, 0, 3, 0);
    tv[7]  = mk(0,0,1,0,   1, 0, 0, 0, 2, 0);
    tv[8]  = mk(0,0,0,0,   1, 0, 0, 0, 2, 0);
    tv[9]  = mk(0,1,1,0,   1, 0, 0, 0, 2, 0);  // opposing steps cancel
    tv[10] = mk(0,0,0,0,   1, 0, 0, 0, 2, 0);
    tv[11] = mk(1,0,0,0,   1, 1, 0, 0, 2, 0);
    tv[12] = mk(0,0,0,0,   1, 1, 0, 0, 2, 0);
    tv[13] = mk(0,0,1,0,   1, 1, 0, 0, 2, 59); // 0-1 -> 59
    tv[14] = mk(0,0,0,0,   1, 1, 0, 0, 2, 59);
    tv[15] = mk(0,1,0,0,   1, 1, 0, 0, 2, 0);  // 59+1 -> 0, no carry
    tv[16] = mk(0,0,0,0,   1, 1, 0, 0, 2, 0);
    tv[17] = mk(0,0,1,0,   1, 1, 0, 0, 2, 59);
    tv[18] = mk(0,0,0,0,   1, 1, 0, 0, 2, 59);
    tv[19] = mk(1,0,0,0,   0, 0, 0, 1, 2, 59); // exit: load strobe
    tv[20] = mk(0,0,0,0,   0, 0, 0, 0, 2, 59); // strobe lasts one cycle
    tv[21] = mk(1,0,0,7,   0, 0, 0, 0, 2, 59); // invalid channel ignored
    tv[22] = mk(0,0,0,0,   0, 0, 0, 0, 2, 59);
    tv[23] = mk(0,1,0,0,   0, 0, 0, 0, 2, 59); // steps ignored in IDLE

`ifdef AUTO_REPEAT_EN
    hold_exp = '{23,23,23,23,23,0,0,0,1,1,1,2,2,2};
`else
    hold_exp = '{23,23,23,23,23,23,23,23,23,23,23,23,23,23};
`endif

    reset = 1'b1; btn_set = 0; btn_up = 0; btn_down = 0; ch_sel = 0;
    load_seen = 0;
    repeat (3) @(negedge clk);
    chk("rst.hours", 64'(ch_hours), 64'd0);
    chk("rst.mins",  64'(ch_mins),  64'd0);
    chk("rst.flags", 64'({editing, edit_field, edit_ch, time_load}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      btn_set = tv[i].s; btn_up = tv[i].u; btn_down = tv[i].d; ch_sel = tv[i].sel;
      @(negedge clk);
      chk($sformatf("vec%0d.editing", i), 64'(editing),    64'(tv[i].ed));
      chk($sformatf("vec%0d.field", i),   64'(edit_field), 64'(tv[i].fld));
      chk($sformatf("vec%0d.ch", i),      64'(edit_ch),    64'(tv[i].ech));
      chk($sformatf("vec%0d.load", i),    64'(time_load),  64'(tv[i].ld));
      chk($sformatf("vec%0d.h0", i),      64'(ch_hours[7:0]), 64'(tv[i].h0));
      chk($sformatf("vec%0d.m0", i),      64'(ch_mins[7:0]),  64'(tv[i].m0));
      chk_model($sformatf("vec%0d", i));
    end
    cyc(0, 0, 0, 0, "vec_end");

    // Alarm channel 2: hours 7, minutes 30, no load strobe.
    load_seen = 0;
    press(1, 0, 0, 2, "alm");
    chk("alm.ch", 64'(edit_ch), 64'd2);
    for (int i = 0; i < 7; i++)  press(0, 1, 0, 2, "alm");
    press(1, 0, 0, 2, "alm");
    for (int i = 0; i < 30; i++) press(0, 1, 0, 2, "alm");
    press(1, 0, 0, 2, "alm");
    chk("alm.h2",   64'(ch_hours[23:16]), 64'd7);
    chk("alm.m2",   64'(ch_mins[23:16]),  64'd30);
    chk("alm.ch0",  64'({ch_hours[7:0], ch_mins[7:0]}), 64'({8'd2, 8'd59}));
    chk("alm.ch1",  64'({ch_hours[15:8], ch_mins[15:8]}), 64'd0);
    chk("alm.noload", 64'(load_seen), 64'd0);

    // Timeout: step at idle cycle 19 restarts the count.
    cyc(1, 0, 0, 0, "tmo");                         // entry edge E
    for (int i = 1; i <= 18; i++) cyc(0, 0, 0, 0, "tmo");
    cyc(0, 1, 0, 0, "tmo");                         // step at E+19
    for (int i = 1; i <= 19; i++) cyc(0, 0, 0, 0, "tmo");
    chk("tmo.still_edit", 64'(editing), 64'd1);
    cyc(0, 0, 0, 0, "tmo");
    chk("tmo.idle",  64'(editing),   64'd0);
    chk("tmo.load",  64'(time_load), 64'd1);
    chk("tmo.keep",  64'(ch_hours[7:0]), 64'd3);
    cyc(0, 0, 0, 0, "tmo");
    chk("tmo.load1", 64'(time_load), 64'd0);

    // Press-and-hold from hours=22.
    press(1, 0, 0, 0, "hold");
    press(0, 0, 1, 0, "hold");
    for (int i = 0; i < 4; i++) press(0, 0, 1, 0, "hold");    // 3 -> 22
    chk("hold.start", 64'(ch_hours[7:0]), 64'd22);
    for (int j = 0; j < 14; j++) begin
      cyc(0, 1, 0, 0, "hold");
      chk($sformatf("hold.k%0d", j), 64'(ch_hours[7:0]), 64'(hold_exp[j]));
    end
    cyc(0, 0, 0, 0, "hold");

    // Async reset in SET_MINS clears everything without a load strobe.
    press(1, 0, 0, 0, "rmid");
    chk("rmid.mins_state", 64'(edit_field), 64'd1);
    press(0, 1, 0, 0, "rmid");
    #2 reset = 1'b1;
    #1;
    chk("rmid.hours", 64'(ch_hours), 64'd0);
    chk("rmid.mins",  64'(ch_mins),  64'd0);
    chk("rmid.flags", 64'({editing, edit_field, edit_ch, time_load}), 64'd0);
    @(negedge clk);
    chk("rmid.noload", 64'(time_load), 64'd0);
    reset = 1'b0;

    // Random stimulus against the model.
    begin
      bit u = 0, d = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) u = ~u;
        if ($urandom_range(0, 7) == 0) d = ~d;
        cyc(bit'($urandom_range(0, 9) == 0), u, d, 3'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
